// File: rtl/booth_accum_pkg.sv
// Shared types and defaults for the booth_accum dot-product accumulator.
// Integration code imports this for the state encoding and default sizes.
package booth_accum_pkg;

  localparam int unsigned MUL_LAT_DEF = 3;
  localparam int unsigned ACC_W_DEF   = 24;
  localparam int unsigned LEN_W       = 8;
  localparam int unsigned PROD_W      = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

endpackage

// File: rtl/booth_accum_valid_pipe.sv
// Valid delay line: a 1 pushed at an issue appears on tap_o DEPTH cycles later,
// lining up with the multiplier result for that issue.
module valid_pipe #(
  parameter int unsigned DEPTH = 3
) (
  input  logic CLK,
  input  logic RST,
  input  logic push_i,
  output logic tap_o
);

  logic [DEPTH-1:0] pipe_q;
  logic [DEPTH-1:0] pipe_d;

  generate
    if (DEPTH == 1) begin : g_single
      always_comb pipe_d = push_i;
    end else begin : g_shift
      always_comb pipe_d = {pipe_q[DEPTH-2:0], push_i};
    end
  endgenerate

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign tap_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/booth_accum.sv
// Dot-product accumulator behind a fixed-latency multiplier: issues len operand
// pairs, sums the returning products, then holds the group sum until accepted.
module booth_accum
  import booth_accum_pkg::*;
#(
  parameter int unsigned MUL_LAT = MUL_LAT_DEF,
  parameter int unsigned ACC_W   = ACC_W_DEF
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     start,
  input  logic [LEN_W-1:0]         len,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [PROD_W-1:0] product,
  output logic signed [ACC_W-1:0]  sum,
  output logic                     sum_valid,
  input  logic                     sum_ready,
  output logic                     busy
);

  state_e                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [ACC_W-1:0]  sum_q, sum_d;
  logic [LEN_W-1:0]         len_q, len_d;
  logic [LEN_W-1:0]         issued_q, issued_d;
  logic [LEN_W-1:0]         received_q, received_d;
  logic                     sum_valid_q, busy_q;
  logic                     issue;
  logic                     tap;

  // Ready is a pure function of state and counts so the source sees it same-cycle.
  assign in_ready = (state_q == ST_ACCUM) && (issued_q < len_q);
  assign issue    = in_valid && in_ready;

  valid_pipe #(
    .DEPTH (MUL_LAT)
  ) u_valid_pipe (
    .CLK    (CLK),
    .RST    (RST),
    .push_i (issue),
    .tap_o  (tap)
  );

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    sum_d      = sum_q;
    len_d      = len_q;
    issued_d   = issued_q;
    received_d = received_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          len_d = len;
          if (len != '0) begin
            state_d    = ST_ACCUM;
            acc_d      = '0;
            issued_d   = '0;
            received_d = '0;
          end else begin
            state_d = ST_HOLD;
            sum_d   = '0;
          end
        end
      end

      ST_ACCUM: begin
        if (issue) begin
          issued_d = issued_q + LEN_W'(1);
        end
        if (tap) begin
          acc_d      = acc_q + ACC_W'(product);
          received_d = received_q + LEN_W'(1);
        end
        // Leave on the edge that retires the last product so sum includes it.
        if (received_d == len_q) begin
          state_d = ST_HOLD;
          sum_d   = acc_d;
        end
      end

      ST_HOLD: begin
        if (sum_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      sum_q       <= '0;
      len_q       <= '0;
      issued_q    <= '0;
      received_q  <= '0;
      sum_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      sum_q       <= sum_d;
      len_q       <= len_d;
      issued_q    <= issued_d;
      received_q  <= received_d;
      sum_valid_q <= (state_d == ST_HOLD);
      busy_q      <= (state_d != ST_IDLE);
    end
  end

  assign sum       = sum_q;
  assign sum_valid = sum_valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_booth_accum.sv
// Bench for booth_accum: models the external multiplier and scores group sums.
module tb_booth_accum;

  localparam int LAT = 3;
  localparam int AW  = 24;

  logic                  CLK = 1'b0;
  logic                  RST;
  logic                  start;
  logic [7:0]            len;
  logic                  in_valid;
  logic                  in_ready;
  logic signed [15:0]    product;
  logic signed [AW-1:0]  sum;
  logic                  sum_valid;
  logic                  sum_ready;
  logic                  busy;

  logic signed [7:0]     op_a, op_b;
  logic signed [15:0]    mp [LAT];
  logic signed [7:0]     va [256];
  logic signed [7:0]     vb [256];
  bit                    pat [4];
  int                    plen;
  int                    cyc = 0;
  int                    checks = 0;
  int                    failures = 0;
  longint                exp_q [$];

  booth_accum #(.MUL_LAT(LAT), .ACC_W(AW)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .product   (product),
    .sum       (sum),
    .sum_valid (sum_valid),
    .sum_ready (sum_ready),
    .busy      (busy)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic signed [15:0] mul16(input logic signed [7:0] a,
                                                input logic signed [7:0] b);
    logic signed [15:0] ae, be;
    ae = a;
    be = b;
    return ae * be;
  endfunction

  // External multiplier: result appears LAT cycles after capture; junk otherwise.
  always @(posedge CLK) begin
    mp[0] <= (in_valid && in_ready) ? mul16(op_a, op_b) : 16'sh5A5A;
    for (int i = 1; i < LAT; i++) mp[i] <= mp[i-1];
  end
  assign product = mp[LAT-1];

  task automatic do_group(input int n, input int hold_cyc, input bit chk_lat);
    int s, i, k, guard, got, want;
    longint e;
    bit ir_seen, stable_ok;
    logic signed [AW-1:0] held;
    e = 0;
    for (int j = 0; j < n; j++) e += longint'(mul16(va[j], vb[j]));
    exp_q.push_back(e);

    @(negedge CLK);
    start = 1'b1;
    len   = 8'(n);
    s     = cyc;
    @(negedge CLK);
    start = 1'b0;
    i = 0; k = 0; guard = 0;
    while (i < n && guard < 3000) begin
      in_valid = pat[k % plen];
      op_a = va[i];
      op_b = vb[i];
      if (in_valid && in_ready) i++;
      k++;
      guard++;
      @(negedge CLK);
    end
    in_valid = 1'b0;
    checks++;
    if (i != n) begin
      failures++;
      $display("FAIL issue_timeout issued=%0d required=%0d", i, n);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL ready_after_last got=%b want=0", in_ready);
    end

    guard = 0;
    ir_seen = 1'b0;
    while (sum_valid !== 1'b1 && guard < 600) begin
      if (in_ready !== 1'b0) ir_seen = 1'b1;
      @(negedge CLK);
      guard++;
    end
    checks++;
    if (sum_valid !== 1'b1) begin
      failures++;
      $display("FAIL sum_valid_timeout got=%b want=1", sum_valid);
    end
    checks++;
    if (ir_seen) begin
      failures++;
      $display("FAIL ready_while_draining got=1 want=0");
    end
    if (chk_lat) begin
      got  = cyc - s;
      want = (n == 0) ? 1 : n + LAT + 1;
      checks++;
      if (got != want) begin
        failures++;
        $display("FAIL latency len=%0d got=%0d want=%0d", n, got, want);
      end
    end
    e = exp_q.pop_front();
    checks++;
    if (sum !== AW'(e)) begin
      failures++;
      $display("FAIL sum len=%0d got=%0d want=%0d", n, sum, e);
    end
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL busy_in_hold got=%b want=1", busy);
    end

    held = sum;
    stable_ok = 1'b1;
    sum_ready = 1'b0;
    for (int c = 0; c < hold_cyc; c++) begin
      start    = c[0];
      len      = 8'd7;
      in_valid = 1'b1;
      @(negedge CLK);
      if (sum !== held || sum_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1)
        stable_ok = 1'b0;
    end
    start = 1'b0;
    in_valid = 1'b0;
    if (hold_cyc > 0) begin
      checks++;
      if (!stable_ok) begin
        failures++;
        $display("FAIL hold_stable sum=%0d held=%0d sv=%b ir=%b", sum, held, sum_valid, in_ready);
      end
    end

    // Accept and pulse start in the same cycle: must return to IDLE only.
    sum_ready = 1'b1;
    start     = 1'b1;
    len       = 8'd5;
    @(negedge CLK);
    sum_ready = 1'b0;
    start     = 1'b0;
    checks++;
    if (busy !== 1'b0 || sum_valid !== 1'b0) begin
      failures++;
      $display("FAIL release_to_idle busy=%b sv=%b want=0,0", busy, sum_valid);
    end
    @(negedge CLK);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL start_ignored_on_release busy=%b want=0", busy);
    end
  endtask

  task automatic set_pat_all;
    pat[0] = 1'b1; plen = 1;
  endtask

  task automatic test_reset;
    RST = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; sum_ready = 1'b0;
    op_a = '0; op_b = '0;
    #2 RST = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b0 || sum_valid !== 1'b0 || sum !== '0) begin
      failures++;
      $display("FAIL reset_state ir=%b busy=%b sv=%b sum=%0d want 0,0,0,0",
               in_ready, busy, sum_valid, sum);
    end
    RST = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_basic;
    set_pat_all();
    va[0] = 8'sd3;  vb[0] = 8'sd4;
    va[1] = -8'sd5; vb[1] = 8'sd6;
    va[2] = 8'sd7;  vb[2] = -8'sd8;
    do_group(3, 1, 1'b1);
  endtask

  task automatic test_len255;
    set_pat_all();
    for (int j = 0; j < 255; j++) begin
      va[j] = -8'sd128; vb[j] = -8'sd128;
    end
    do_group(255, 0, 1'b1);
  endtask

  task automatic test_len0;
    set_pat_all();
    do_group(0, 2, 1'b1);
  endtask

  task automatic test_gapped;
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1; plen = 4;
    va[0] = 8'sd11;  vb[0] = -8'sd9;
    va[1] = -8'sd20; vb[1] = -8'sd3;
    do_group(2, 0, 1'b0);
  endtask

  task automatic test_hold_stall;
    set_pat_all();
    for (int j = 0; j < 4; j++) begin
      va[j] = 8'($urandom); vb[j] = 8'($urandom);
    end
    do_group(4, 10, 1'b1);
  endtask

  task automatic test_back_to_back;
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b1; plen = 3;
    for (int g = 0; g < 3; g++) begin
      for (int j = 0; j < 6; j++) begin
        va[j] = 8'($urandom); vb[j] = 8'($urandom);
      end
      do_group(6, g, 1'b0);
    end
  endtask

  task automatic test_reset_midgroup;
    @(negedge CLK);
    start = 1'b1;
    len   = 8'd4;
    @(negedge CLK);
    start = 1'b0;
    for (int j = 0; j < 2; j++) begin
      in_valid = 1'b1;
      op_a = 8'sd50;
      op_b = 8'sd50;
      @(negedge CLK);
    end
    in_valid = 1'b0;
    RST = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b0 || sum_valid !== 1'b0 || sum !== '0) begin
      failures++;
      $display("FAIL async_reset_mid ir=%b busy=%b sv=%b sum=%0d want 0,0,0,0",
               in_ready, busy, sum_valid, sum);
    end
    @(negedge CLK);
    RST = 1'b1;
    set_pat_all();
    va[0] = 8'sd2; vb[0] = 8'sd2;
    do_group(1, 1, 1'b1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_len255();
    test_len0();
    test_gapped();
    test_hold_stall();
    test_back_to_back();
    test_reset_midgroup();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
